seg7_scan_ctrl: RTL and testbench

- Sequencing controller for the 4-digit time-multiplexed seven-segment display.
- Accepts an 8-bit binary value over a ready/load handshake and converts it to BCD iteratively (shift-add-3, one bit per cycle).
- Commits the result to a display register, then scans the four anodes at a programmable refresh rate, driving the segment pattern for the active digit.
- Sits between the processor's output register and the board display pins.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/bcd_to_seg7.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
//   - state_t       : conversion FSM states
//   - NUM_DIGITS    : number of multiplexed digits
//   - SEG_*         : active-low segment patterns {g,f,e,d,c,b,a}
//   - BIT_CNT_*     : shift counter width and terminal value (8 shifts)
//   - dabble_shift  : one shift-add-3 step on the {bcd[11:0], bin[7:0]} register
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam int              BIT_CNT_W    = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 4'd7;

    // Correct every BCD nibble that would overflow on doubling, then shift.
    function automatic logic [19:0] dabble_shift(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low seven-segment decoder.
//   digit : 4-bit BCD value (10..15 decode to blank)
//   blank : force all segments off
//   seg   : {g,f,e,d,c,b,a}, active low
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: converts an 8-bit binary value to BCD (one bit per cycle)
// and scans it onto a 4-digit multiplexed seven-segment display.
//   clk     : system clock, rising edge
//   reset   : synchronous, active high
//   value   : binary value, sampled when a load is accepted
//   load    : request conversion/display of value
//   ready   : high when a load will be accepted
//   bcd_out : committed BCD {hundreds,tens,ones}
//   an      : anode enables, active low, an[0] = ones
//   seg     : {g,f,e,d,c,b,a}, active low
// Parameter REFRESH_DIV: clock cycles per digit slot (>= 1).
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        load,
    output logic        ready,
    output logic [11:0] bcd_out,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t                 state;
    logic [19:0]            sr;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    logic [CNT_W-1:0]       div_cnt;
    logic [IDX_W-1:0]       scan_idx;
    logic [IDX_W-1:0]       next_idx;
    logic [3:0]             digit;
    logic                   blank;
    logic [6:0]             seg_next;

    // Conversion FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            bcd_out <= '0;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sr      <= {12'h000, value};
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr <= dabble_shift(sr);
                    if (bit_cnt == BIT_CNT_LAST)
                        state <= COMMIT;
                    else
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
                COMMIT: begin
                    bcd_out <= sr[19:8];
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The outputs are registered at the slot change, so the decoder looks
    // at the digit that becomes active on that edge, not the current one.
    assign next_idx = scan_idx + IDX_W'(1);

    always_comb begin
        digit = 4'h0;
        blank = 1'b0;
        case (next_idx)
            2'd0:    digit = bcd_out[3:0];
            2'd1:    digit = bcd_out[7:4];
            2'd2:    digit = bcd_out[11:8];
            default: digit = 4'h0;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (next_idx)
            2'd1:    blank = (bcd_out[11:8] == 4'h0) && (bcd_out[7:4] == 4'h0);
            2'd2:    blank = (bcd_out[11:8] == 4'h0);
            2'd3:    blank = 1'b1;
            default: blank = 1'b0;
        endcase
`endif
    end

    bcd_to_seg7 u_dec (
        .digit (digit),
        .blank (blank),
        .seg   (seg_next)
    );

    // Refresh divider and anode scan
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            scan_idx <= next_idx;
            an       <= ~(4'b0001 << next_idx);
            seg      <= seg_next;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl with
// REFRESH_DIV = 4. Expected segment values follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic        load;
    logic        ready;
    logic [11:0] bcd_out;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .load    (load),
        .ready   (ready),
        .bcd_out (bcd_out),
        .an      (an),
        .seg     (seg)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = 8'h00;
        step(); step(); step();
        n_cmp++; if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an: got %b expected %b", an, 4'b1111); end
        n_cmp++; if (seg !== 7'b1111111) begin n_err++; $display("FAIL reset_seg: got %b expected %b", seg, 7'b1111111); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_cmp++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h expected 000", bcd_out); end
        reset = 1'b0;
    endtask

    task automatic test_convert_255();
        value = 8'd255; load = 1'b1;
        step();                       // edge t
        load = 1'b0;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL conv255_ready_t: got %b expected 0", ready); end
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL conv255_busy[%0d]: got %b expected 0", i, ready); end
        end
        step();                       // edge t+9
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL conv255_ready_done: got %b expected 1", ready); end
        n_cmp++; if (bcd_out !== 12'h255) begin n_err++; $display("FAIL conv255_bcd: got %h expected 255", bcd_out); end
    endtask

    task automatic test_ignored_load();
        value = 8'd200; load = 1'b1;
        step();                       // edge t
        load = 1'b0;
        step(); step();
        value = 8'd7; load = 1'b1;
        step();                       // edge t+3, must be ignored
        load = 1'b0;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ign_ready_busy: got %b expected 0", ready); end
        for (int i = 0; i < 6; i++) step();   // edge t+9
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ign_ready_done: got %b expected 1", ready); end
        n_cmp++; if (bcd_out !== 12'h200) begin n_err++; $display("FAIL ign_bcd: got %h expected 200", bcd_out); end
        for (int i = 0; i < 12; i++) step();
        n_cmp++; if (bcd_out !== 12'h200) begin n_err++; $display("FAIL ign_not_queued: got %h expected 200", bcd_out); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ign_ready_idle: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid_conversion();
        value = 8'd99; load = 1'b1;
        step();                       // edge t
        load = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();                       // edge t+4
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b expected 1", ready); end
        n_cmp++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL mid_bcd: got %h expected 000", bcd_out); end
        n_cmp++; if (an !== 4'b1111) begin n_err++; $display("FAIL mid_an: got %b expected 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_err++; $display("FAIL mid_seg: got %b expected 1111111", seg); end
        value = 8'd5; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_cmp++; if (bcd_out !== 12'h005) begin n_err++; $display("FAIL mid_reload_bcd: got %h expected 005", bcd_out); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_reload_ready: got %b expected 1", ready); end
    endtask

    // Reset, load v right after release (edge R+1), then follow the scan:
    // anode slot k/4 mod 4 after edge R+k, first slot change at R+4,
    // committed value visible from the slot starting at R+12.
    task automatic test_scan(input logic [7:0] v, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3);
        logic [11:0] exp_bcd;
        logic [6:0]  exp_seg [4];
        logic [3:0]  exp_an;
        int          idx;
        exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        reset = 1'b1; load = 1'b0;
        step(); step();               // edge R
        reset = 1'b0; value = v; load = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 1) load = 1'b0;
            if (k < 4) begin
                n_cmp++; if (an !== 4'b1111) begin n_err++; $display("FAIL scan%0d_an_pre[%0d]: got %b expected 1111", v, k, an); end
            end
            if (k == 10) begin
                n_cmp++; if (bcd_out !== exp_bcd) begin n_err++; $display("FAIL scan%0d_bcd: got %h expected %h", v, bcd_out, exp_bcd); end
            end
            if (k >= 12) begin
                idx    = (k / 4) % 4;
                exp_an = ~(4'b0001 << idx);
                n_cmp++; if (an !== exp_an) begin n_err++; $display("FAIL scan%0d_an[%0d]: got %b expected %b", v, k, an, exp_an); end
                n_cmp++; if (seg !== exp_seg[idx]) begin n_err++; $display("FAIL scan%0d_seg[%0d]: got %b expected %b", v, k, seg, exp_seg[idx]); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = 8'h00;
        test_reset();
        test_convert_255();
        test_ignored_load();
        test_reset_mid_conversion();
        test_scan(8'd128, 7'b0000000, 7'b0100100, 7'b1111001, LZ);
        test_scan(8'd7,   7'b1111000, LZ, LZ, LZ);
        test_scan(8'd0,   7'b1000000, LZ, LZ, LZ);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
